// File: rtl/nios_jtag_dbg_pkg.sv
// Shared constants, instruction encodings and helpers for the
// virtual-JTAG debug command queue.
package nios_jtag_dbg_pkg;

    localparam int SR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int DEPTH_DEF       = 4;
    localparam int ACT_BIT_DEF     = 34;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } jtag_ir_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_jtag_sync_edge.sv
// Synchroniser chain plus rising-edge detector for one TCK-domain
// level, producing a registered single-cycle pulse in the clk domain.
module nios_jtag_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic [STAGES:0]   arm_q, arm_d;
    logic              pulse_q, pulse_d;

    // arm_q holds off detection until the chain and history flop carry
    // real input, so a level already high at reset release is ignored
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], d_in};
        hist_d  = sync_q[STAGES-1];
        arm_d   = {arm_q[STAGES-1:0], 1'b1};
        pulse_d = sync_q[STAGES-1] & ~hist_q & arm_q[STAGES];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            arm_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            arm_q   <= arm_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/nios_jtag_debug_cmdq.sv
// Clock-domain command queue between the virtual-JTAG TAP and the
// debug module: captures IR/DR updates and replays them as strobes.
module nios_jtag_debug_cmdq
    import nios_jtag_dbg_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int N_IR       = 1 << IR_W,
    localparam int PW         = clog2(DEPTH),
    localparam int LW         = PW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_uir,
    input  logic            vs_udr,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            cmd_ready,
    input  logic            clr_ovf,
    output logic            cmd_valid,
    output logic [IR_W-1:0] cmd_ir,
    output logic [SR_W-1:0] jdo,
    output logic [N_IR-1:0] take_action,
    output logic [N_IR-1:0] take_no_action,
    output logic [LW-1:0]   level,
    output logic            ovf
);

    logic uir_p;
    logic udr_p;

    nios_jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (vs_uir),
        .pulse   (uir_p)
    );

    nios_jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (vs_udr),
        .pulse   (udr_p)
    );

    logic [IR_W-1:0] ir_mem_q [DEPTH];
    logic [SR_W-1:0] sr_mem_q [DEPTH];

    logic [IR_W-1:0] ir_reg_q, ir_reg_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [SR_W-1:0] jdo_q, jdo_d;
    logic [N_IR-1:0] ta_q, ta_d;
    logic [N_IR-1:0] tna_q, tna_d;

    logic            push;
    logic            pop;
    logic            drop;
    logic [SR_W-1:0] head_sr;

    assign cmd_valid = (level_q != '0);
    assign cmd_ir    = ir_mem_q[rptr_q];
    assign head_sr   = sr_mem_q[rptr_q];

    always_comb begin
        pop      = cmd_valid & cmd_ready;
        push     = udr_p & ((level_q != LW'(DEPTH)) | pop);
        drop     = udr_p & ~push;
        ir_reg_d = uir_p ? ir_in : ir_reg_q;
        wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d   = pop ? rptr_q + PW'(1) : rptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        // a drop in the same cycle as a clear keeps the flag set
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        jdo_d = pop ? head_sr : jdo_q;
        ta_d  = '0;
        tna_d = '0;
        if (pop) begin
            if (head_sr[ACT_BIT]) begin
                ta_d[cmd_ir] = 1'b1;
            end else begin
                tna_d[cmd_ir] = 1'b1;
            end
        end
    end

    // push captures ir_reg_q before any same-cycle IR update lands
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem_q[wptr_q] <= ir_reg_q;
            sr_mem_q[wptr_q] <= sr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            jdo_q    <= '0;
            ta_q     <= '0;
            tna_q    <= '0;
        end else begin
            ir_reg_q <= ir_reg_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            jdo_q    <= jdo_d;
            ta_q     <= ta_d;
            tna_q    <= tna_d;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign level          = level_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_nios_jtag_debug_cmdq.sv
// Scoreboard bench for the JTAG debug command queue: expected
// commands are queued at drive time and matched against strobes.
module tb_nios_jtag_debug_cmdq;
    import nios_jtag_dbg_pkg::*;

    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int N_IR = 4;
    localparam int LW   = 3;

    logic            clk;
    logic            reset_n;
    logic            vs_uir;
    logic            vs_udr;
    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic            cmd_ready;
    logic            clr_ovf;
    logic            cmd_valid;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] jdo;
    logic [N_IR-1:0] take_action;
    logic [N_IR-1:0] take_no_action;
    logic [LW-1:0]   level;
    logic            ovf;

    nios_jtag_debug_cmdq dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .clr_ovf        (clr_ovf),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .level          (level),
        .ovf            (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } exp_t;

    exp_t sb[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;
    int cyc = 0;
    int last_cyc = -10;
    int run_len = 0;
    int max_level = 0;
    logic [IR_W-1:0] cur_ir = '0;

    exp_t            mon_e;
    logic [N_IR-1:0] mon_ta;
    logic [N_IR-1:0] mon_tna;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (int'(level) > max_level) max_level = int'(level);
        if ((take_action | take_no_action) != '0) begin
            strobe_cnt = strobe_cnt + 1;
            run_len = (cyc == last_cyc + 1) ? run_len + 1 : 1;
            last_cyc = cyc;
            cmp_cnt = cmp_cnt + 1;
            if (sb.size() == 0) begin
                err_cnt = err_cnt + 1;
                $display("FAIL strobe_unexpected ta=%b tna=%b jdo=%h",
                         take_action, take_no_action, jdo);
            end else begin
                mon_e = sb.pop_front();
                mon_ta = '0;
                mon_tna = '0;
                if (mon_e.data[34]) mon_ta[mon_e.ir] = 1'b1;
                else mon_tna[mon_e.ir] = 1'b1;
                if (jdo !== mon_e.data || take_action !== mon_ta
                    || take_no_action !== mon_tna) begin
                    err_cnt = err_cnt + 1;
                    $display("FAIL strobe_data got ta=%b tna=%b jdo=%h exp ta=%b tna=%b jdo=%h",
                             take_action, take_no_action, jdo,
                             mon_ta, mon_tna, mon_e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [IR_W-1:0] v);
        ir_in = v;
        vs_uir = 1'b1;
        tick(5);
        vs_uir = 1'b0;
        tick(3);
        cur_ir = v;
    endtask

    task automatic send_dr(input logic [SR_W-1:0] d, input bit exp_push);
        sr = d;
        if (exp_push) sb.push_back('{cur_ir, d});
        vs_udr = 1'b1;
        tick(5);
        vs_udr = 1'b0;
        tick(4);
    endtask

    function automatic logic [SR_W-1:0] rnd_data(input bit act);
        logic [SR_W-1:0] d;
        d = {6'($urandom), $urandom};
        d[34] = act;
        return d;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        cmd_ready = 1'b1;
        while (level != '0 && n < 50) begin
            tick(1);
            n++;
        end
        cmp_cnt++;
        if (level !== '0) begin
            err_cnt++;
            $display("FAIL drain_timeout level=%0d exp=0", level);
        end
        tick(2);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        cmp_cnt += 6;
        if (level !== '0) begin
            err_cnt++; $display("FAIL rst_level got=%0d exp=0", level);
        end
        if (cmd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rst_valid got=%b exp=0", cmd_valid);
        end
        if (ovf !== 1'b0) begin
            err_cnt++; $display("FAIL rst_ovf got=%b exp=0", ovf);
        end
        if (jdo !== '0) begin
            err_cnt++; $display("FAIL rst_jdo got=%h exp=0", jdo);
        end
        if (take_action !== '0) begin
            err_cnt++; $display("FAIL rst_ta got=%b exp=0", take_action);
        end
        if (take_no_action !== '0) begin
            err_cnt++; $display("FAIL rst_tna got=%b exp=0", take_no_action);
        end
        reset_n = 1'b1;
        tick(5);
    endtask

    task automatic test_latency();
        int n;
        logic [SR_W-1:0] d;
        cmd_ready = 1'b0;
        set_ir(IR_TRACEMEM);
        d = rnd_data(1'b1);
        sr = d;
        sb.push_back('{cur_ir, d});
        vs_udr = 1'b1;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        cmp_cnt += 2;
        if (n != 4) begin
            err_cnt++; $display("FAIL udr_latency got=%0d exp=4", n);
        end
        if (cmd_ir !== 2'd1) begin
            err_cnt++; $display("FAIL latency_cmd_ir got=%0d exp=1", cmd_ir);
        end
        tick(2);
        vs_udr = 1'b0;
        tick(4);
        drain();
    endtask

    task automatic test_single_action();
        int s0;
        logic [SR_W-1:0] d;
        s0 = strobe_cnt;
        set_ir(IR_OCIMEM);
        cmd_ready = 1'b1;
        d = rnd_data(1'b1);
        send_dr(d, 1'b1);
        cmd_ready = 1'b0;
        cmp_cnt += 3;
        if (strobe_cnt - s0 != 1) begin
            err_cnt++; $display("FAIL single_strobes got=%0d exp=1", strobe_cnt - s0);
        end
        if (jdo !== d) begin
            err_cnt++; $display("FAIL single_jdo got=%h exp=%h", jdo, d);
        end
        if (level !== '0) begin
            err_cnt++; $display("FAIL single_level got=%0d exp=0", level);
        end
    endtask

    task automatic test_no_action();
        int s0;
        s0 = strobe_cnt;
        set_ir(IR_BREAK);
        cmd_ready = 1'b1;
        send_dr(rnd_data(1'b0), 1'b1);
        cmd_ready = 1'b0;
        cmp_cnt++;
        if (strobe_cnt - s0 != 1) begin
            err_cnt++; $display("FAIL noact_strobes got=%0d exp=1", strobe_cnt - s0);
        end
    endtask

    task automatic test_overflow();
        int s0;
        cmd_ready = 1'b0;
        set_ir(IR_TRACECTRL);
        for (int i = 0; i < 5; i++) begin
            send_dr(rnd_data(i[0]), i < 4);
        end
        cmp_cnt += 3;
        if (level !== 3'd4) begin
            err_cnt++; $display("FAIL ovf_level got=%0d exp=4", level);
        end
        if (ovf !== 1'b1) begin
            err_cnt++; $display("FAIL ovf_set got=%b exp=1", ovf);
        end
        if (cmd_ir !== 2'd3) begin
            err_cnt++; $display("FAIL ovf_cmd_ir got=%0d exp=3", cmd_ir);
        end
        s0 = strobe_cnt;
        drain();
        cmp_cnt += 3;
        if (strobe_cnt - s0 != 4) begin
            err_cnt++; $display("FAIL ovf_drain_cnt got=%0d exp=4", strobe_cnt - s0);
        end
        if (run_len != 4) begin
            err_cnt++; $display("FAIL back_to_back run=%0d exp=4", run_len);
        end
        if (ovf !== 1'b1) begin
            err_cnt++; $display("FAIL ovf_sticky got=%b exp=1", ovf);
        end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        cmp_cnt++;
        if (ovf !== 1'b0) begin
            err_cnt++; $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
    endtask

    task automatic test_full_push_pop();
        logic [SR_W-1:0] d;
        cmd_ready = 1'b0;
        set_ir(IR_OCIMEM);
        for (int i = 0; i < 4; i++) send_dr(rnd_data(!i[0]), 1'b1);
        d = rnd_data(1'b1);
        sr = d;
        sb.push_back('{cur_ir, d});
        vs_udr = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        cmp_cnt += 2;
        if (level !== 3'd4) begin
            err_cnt++; $display("FAIL fullpp_level got=%0d exp=4", level);
        end
        if (ovf !== 1'b0) begin
            err_cnt++; $display("FAIL fullpp_ovf got=%b exp=0", ovf);
        end
        tick(2);
        vs_udr = 1'b0;
        tick(4);
        drain();
    endtask

    task automatic test_wrap();
        max_level = 0;
        set_ir(IR_BREAK);
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_dr(rnd_data(i[1]), 1'b1);
        cmd_ready = 1'b0;
        tick(2);
        cmp_cnt += 2;
        if (max_level > 1) begin
            err_cnt++; $display("FAIL wrap_max_level got=%0d exp<=1", max_level);
        end
        if (sb.size() != 0) begin
            err_cnt++; $display("FAIL wrap_left got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        cmd_ready = 1'b0;
        set_ir(IR_TRACEMEM);
        for (int i = 0; i < 3; i++) send_dr(rnd_data(1'b1), 1'b1);
        cmp_cnt++;
        if (level !== 3'd3) begin
            err_cnt++; $display("FAIL mid_level_pre got=%0d exp=3", level);
        end
        s0 = strobe_cnt;
        sr = rnd_data(1'b1);
        vs_udr = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        cmp_cnt += 2;
        if (level !== '0) begin
            err_cnt++; $display("FAIL mid_async_level got=%0d exp=0", level);
        end
        if (cmd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL mid_async_valid got=%b exp=0", cmd_valid);
        end
        sb.delete();
        tick(3);
        reset_n = 1'b1;
        tick(10);
        cmp_cnt += 3;
        if (level !== '0) begin
            err_cnt++; $display("FAIL mid_held_udr level=%0d exp=0", level);
        end
        if (cmd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL mid_valid got=%b exp=0", cmd_valid);
        end
        if (strobe_cnt != s0) begin
            err_cnt++; $display("FAIL mid_strobes got=%0d exp=%0d", strobe_cnt, s0);
        end
        vs_udr = 1'b0;
        tick(4);
        cur_ir = '0;
        set_ir(IR_TRACECTRL);
        cmd_ready = 1'b1;
        send_dr(rnd_data(1'b0), 1'b1);
        cmd_ready = 1'b0;
        cmp_cnt++;
        if (strobe_cnt - s0 != 1) begin
            err_cnt++; $display("FAIL mid_recover got=%0d exp=1", strobe_cnt - s0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        ir_in = '0;
        sr = '0;
        cmd_ready = 1'b0;
        clr_ovf = 1'b0;
        test_reset();
        test_latency();
        test_single_action();
        test_no_action();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        tick(3);
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
